// File: rtl/frog_motion_ctrl.sv
// Frog position controller: debounced four-way movement clamped to the playfield,
// top-row arrival detection and a blinking death/respawn sequence.
module frog_motion_ctrl #(
    parameter int GRID_W          = 20,
    parameter int GRID_H          = 15,
    parameter int START_X         = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEATH_HOLD      = 12500000,
    parameter int BLINK_CYCLES    = 3125000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    input  logic       collision,
    input  logic       reset_frog,
    output logic [4:0] frog_x,
    output logic [3:0] frog_y,
    output logic       frog_at_top,
    output logic       frog_dead,
    output logic       frog_visible
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W  = $clog2(DEATH_HOLD + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [4:0]         START_X_C    = 5'(START_X);
    localparam logic [3:0]         START_Y_C    = 4'(GRID_H - 1);
    localparam logic [4:0]         MAX_X_C      = 5'(GRID_W - 1);
    localparam logic [DB_W-1:0]    DB_LAST_C    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST_C  = HOLD_W'(DEATH_HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST_C = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_AT_TOP = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    // bit 0 up, bit 1 down, bit 2 left, bit 3 right
    logic [3:0]         sw_raw_s;
    logic [3:0]         sync1_r;
    logic [3:0]         sync2_r;
    logic [3:0]         deb_r;
    logic [3:0]         deb_d_r;
    logic [3:0]         press_r;
    logic [DB_W-1:0]    db_cnt_r [4];
    state_t             state_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [4:0]         next_x_s;
    logic [3:0]         next_y_s;

    assign sw_raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // Synchronize, debounce and register the rising-edge press events of each switch
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'd0;
            sync2_r <= 4'd0;
            deb_r   <= 4'd0;
            deb_d_r <= 4'd0;
            press_r <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= sw_raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            press_r <= deb_r & ~deb_d_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST_C) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Candidate position: highest-priority press event, clamped to the playfield
    always_comb begin
        next_x_s = frog_x;
        next_y_s = frog_y;
        if (press_r[0]) begin
            if (frog_y != 4'd0) next_y_s = frog_y - 4'd1;
            else                next_y_s = frog_y;
        end else if (press_r[1]) begin
            if (frog_y != START_Y_C) next_y_s = frog_y + 4'd1;
            else                     next_y_s = frog_y;
        end else if (press_r[2]) begin
            if (frog_x != 5'd0) next_x_s = frog_x - 5'd1;
            else                next_x_s = frog_x;
        end else if (press_r[3]) begin
            if (frog_x != MAX_X_C) next_x_s = frog_x + 5'd1;
            else                   next_x_s = frog_x;
        end else begin
            next_x_s = frog_x;
            next_y_s = frog_y;
        end
    end

    // Play / top-reached / death state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_PLAY;
            frog_x       <= START_X_C;
            frog_y       <= START_Y_C;
            frog_at_top  <= 1'b0;
            frog_dead    <= 1'b0;
            frog_visible <= 1'b1;
            hold_cnt_r   <= '0;
            blink_cnt_r  <= '0;
        end else begin
            frog_at_top <= 1'b0;
            frog_dead   <= 1'b0;
            case (state_r)
                ST_PLAY: begin
                    frog_visible <= 1'b1;
                    if (collision) begin
                        state_r     <= ST_DEAD;
                        frog_dead   <= 1'b1;
                        hold_cnt_r  <= '0;
                        blink_cnt_r <= '0;
                    end else if (reset_frog) begin
                        frog_x <= START_X_C;
                        frog_y <= START_Y_C;
                    end else begin
                        frog_x <= next_x_s;
                        frog_y <= next_y_s;
                        if (next_y_s == 4'd0) begin
                            state_r     <= ST_AT_TOP;
                            frog_at_top <= 1'b1;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end
                end
                ST_AT_TOP: begin
                    frog_visible <= 1'b1;
                    if (reset_frog) begin
                        frog_x  <= START_X_C;
                        frog_y  <= START_Y_C;
                        state_r <= ST_PLAY;
                    end else begin
                        state_r <= ST_AT_TOP;
                    end
                end
                ST_DEAD: begin
                    if (hold_cnt_r == HOLD_LAST_C) begin
                        state_r      <= ST_PLAY;
                        frog_x       <= START_X_C;
                        frog_y       <= START_Y_C;
                        frog_visible <= 1'b1;
                        hold_cnt_r   <= '0;
                        blink_cnt_r  <= '0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        if (blink_cnt_r == BLINK_LAST_C) begin
                            blink_cnt_r  <= '0;
                            frog_visible <= ~frog_visible;
                        end else begin
                            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
                        end
                    end
                end
                default: begin
                    state_r      <= ST_PLAY;
                    frog_visible <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/frog_motion_ctrl.md
# frog_motion_ctrl

Owns the frog's grid position for the frogger game. It debounces the four Go Board switches and moves the frog one cell per press, clamped to the playfield. It detects arrival at the top row and runs a death/respawn sequence on collision. It sits directly upstream of the level counter: its `frog_at_top` pulse drives the counter's `frog_at_top`, it consumes the counter's `reset_frog`, and its `frog_dead` pulse drives the counter's `reset_level`.

## Interface
Parameters:
- `GRID_W`, 20: playfield columns; must be ≤ 32.
- `GRID_H`, 15: playfield rows; must be ≤ 16. Row 0 is the top; row `GRID_H-1` is the start row.
- `START_X`, 10: spawn column.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a switch change is accepted.
- `DEATH_HOLD`, 12500000: cycles spent in DEAD before respawn.
- `BLINK_CYCLES`, 3125000: toggle period of `frog_visible` while in DEAD.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: **synchronous, active-high** reset.
- `i_Switch_1`, in, 1: raw up button, active high.
- `i_Switch_2`, in, 1: raw down button, active high.
- `i_Switch_3`, in, 1: raw left button, active high.
- `i_Switch_4`, in, 1: raw right button, active high.
- `collision`, in, 1: level-sensitive hit indication from the obstacle logic.
- `reset_frog`, in, 1: respawn request from the level counter.
- `frog_x`, out, 5: current column.
- `frog_y`, out, 4: current row.
- `frog_at_top`, out, 1: registered one-cycle pulse when the frog reaches row 0.
- `frog_dead`, out, 1: registered one-cycle pulse on entering DEAD.
- `frog_visible`, out, 1: sprite enable for the display stage.

## Operation
- Input path, per switch:
  - 2-flop synchronizer, then a debouncer.
  - Debouncer counter increments while the synchronized value differs from the debounced value; it clears to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, the debounced value takes the synchronized value.
  - A press event is a debounced 0→1 edge. Releases never move the frog.
- Simultaneous press events resolve by priority up > down > left > right. Only one move is made per cycle.
- Moves are clamped to the playfield:
  - up at y=0 → no change; down at y=`GRID_H-1` → no change;
  - left at x=0 → no change; right at x=`GRID_W-1` → no change.
- FSM states: PLAY, AT_TOP, DEAD.
- PLAY:
  - The press event is applied.
  - If the new y is 0: go to AT_TOP and assert `frog_at_top` for that same cycle.
  - If `collision`=1: go to DEAD, assert `frog_dead` for 1 cycle, and do not apply the move.
  - Collision has priority over the move and over reaching the top.
- AT_TOP:
  - Position holds and press events are discarded.
  - On `reset_frog`=1: position becomes (`START_X`, `GRID_H-1`) and the state returns to PLAY.
  - `collision` is ignored.
- DEAD:
  - Position holds; press events and `reset_frog` are ignored.
  - A hold counter counts 0..`DEATH_HOLD-1`. `frog_visible` toggles each time the blink counter reaches `BLINK_CYCLES-1`.
  - When the hold counter expires: position goes to start, `frog_visible`=1, state goes to PLAY.
- `reset_frog`=1 in PLAY also forces the start position. It wins over a same-cycle press.
- `frog_visible`=1 in PLAY and AT_TOP.
- Pending debounce state is not cleared on state change. A press that completes during AT_TOP or DEAD is lost.

## Timing
- Values after `reset`:
  - `frog_x`=`START_X`, `frog_y`=`GRID_H-1`;
  - `frog_at_top`=0, `frog_dead`=0, `frog_visible`=1;
  - state PLAY; all counters 0;
  - synchronizers and debounced values 0.
- `reset` asserted mid-operation (including in DEAD or AT_TOP) restores these values on the next edge.
- Latency from a raw switch rising at edge k (held stable) to the position update is edge k+`DEBOUNCE_CYCLES`+3.
- `frog_at_top` and `frog_dead` are high for exactly one cycle, on the same edge that updates the state.
- The level counter derives `reset_frog` combinationally from `frog_at_top`, so `reset_frog` arrives during the first AT_TOP cycle. The position is at start one edge after `frog_at_top` rises, so AT_TOP normally lasts 1 cycle.
- DEAD lasts exactly `DEATH_HOLD` cycles. The start position appears on the edge after the last DEAD cycle.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DEATH_HOLD`=16, `BLINK_CYCLES`=4, with the level counter modelled as `reset_frog`=`frog_at_top`.

1. Reset → x=10, y=14, `frog_visible`=1, both pulses 0. A 3-cycle glitch on `i_Switch_1` → no move. A held press → y=13 exactly 7 edges after the raw rise.
2. Fourteen separate up presses → `frog_at_top` single pulse as y reaches 0. Next edge → x=10, y=14, PLAY. Holding `i_Switch_1` does not repeat the move.
3. 11 right presses from x=10 → x stops at 19. 25 left presses → x stops at 0. Down at y=14 → y stays 14.
4. `collision`=1 with an up press on the same cycle at y=1 → `frog_dead` pulse, no `frog_at_top`, y stays 1. `frog_visible` toggles every 4 cycles. Presses ignored. Start position restored after 16 cycles.
5. `i_Switch_1` and `i_Switch_4` debounced on the same cycle → only y decrements.
6. `reset` asserted in cycle 5 of DEAD → next edge gives reset values and PLAY, `frog_visible`=1.
